rv32_issue_scoreboard: RTL and testbench
========================================

// Module: rv32_issue_scoreboard
// PURPOSE
// - Issue controller between rv32 decode and execute. Tracks pending register writes in a 32-entry scoreboard.
// - Holds decoded instructions back on RAW/WAW hazards against in-flight writes.
// - Presents each accepted instruction on a one-deep registered issue stage with a valid/ready handshake.
// - Writeback ports clear scoreboard entries as results retire.
// PARAMETERS
// - WB_PORTS   2   number of independent writeback clear ports (1..4)
// PORTS
// - clk           in   1              clock; all logic on rising edge
// - rst           in   1              synchronous, active-high reset
// - dec_valid     in   1              decoded instruction offered
// - dec_ready     out  1              instruction accepted this cycle when dec_valid && dec_ready
// - dec_fields    in   rv32_fields_t  decoded instruction
// - dec_uses_rs1  in   1              instruction reads rs1
// - dec_uses_rs2  in   1              instruction reads rs2
// - dec_writes_rd in   1              instruction writes rd
// - iss_valid     out  1              issue stage holds an instruction
// - iss_ready     in   1              execute consumes when iss_valid && iss_ready
// - iss_fields    out  rv32_fields_t  held instruction
// - iss_writes_rd out  1              held instruction marked rd busy
// - wb_valid      in   WB_PORTS       writeback port k retiring a write
// - wb_addr       in   WB_PORTS x 5   register address per port
// - flush         in   1              discard held instruction (branch redirect)
// - busy_mask     out  32             scoreboard state; bit 0 always 0
// - sb_error      out  1              sticky: clear of a non-busy register seen
// BEHAVIOUR
// - Reset: iss_valid=0, iss_fields=0, iss_writes_rd=0, busy_mask=0, sb_error=0. dec_ready is 0 during the reset cycle.
// - Hazard check uses only registered busy_mask; no same-cycle writeback bypass.
//   - hazard = (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || (writes_rd && busy[rd])
//   - Index 0 is never busy, so x0 never hazards.
// - Decode errors: if dec_fields.decode_error, the instruction issues without a hazard check and never marks rd.
//   - It reaches execute as an exception carrier.
// - slot_free = !iss_valid || iss_ready.
// - dec_ready = slot_free && !hazard && !flush && !rst.
// - Accept on dec_valid && dec_ready:
//   - iss_fields <= dec_fields; iss_valid <= 1; latency decode->issue is 1 cycle.
//   - If writes_rd && rd!=0 && !decode_error: busy[rd] <= 1 and iss_writes_rd <= 1; otherwise iss_writes_rd <= 0.
// - Consume without a new accept: iss_valid <= 0. Back-to-back accept and consume sustains 1 instruction/cycle.
// - Writeback: for each k with wb_valid[k] && wb_addr[k]!=0, busy[wb_addr[k]] <= 0.
//   - If that bit was already 0, sb_error <= 1.
//   - sb_error stays set until rst.
// - Same cycle set and clear on one register: the set wins. WAW stall makes this legal only when a stale clear races; the error flag still fires.
// - Multiple ports clearing the same register in one cycle is legal: one clear, no error.
// - Flush:
//   - dec_ready forced 0; iss_valid <= 0.
//   - If the held instruction had iss_writes_rd, busy[iss_fields.rd] <= 0, reverting its own mark.
//   - Safe because WAW stall guarantees a single owner per busy bit.
//   - flush has priority over iss_ready that cycle.
//   - Writebacks in the same cycle still apply.
// - Handshake rules: iss_fields stable while iss_valid && !iss_ready. Upstream may drop dec_valid freely.
// - Reset mid-operation: all state cleared next edge; in-flight writebacks after reset raise sb_error, so the pipeline must reset together.
// STRUCTURE
// - rv32 package additions: rv32_reg_mask_t (logic [31:0]) and function rv32_hazard(fields, uses_rs1, uses_rs2, writes_rd, mask).
// - Sub-module rv32_scoreboard_bits holds the 32-bit busy vector with set/clear/flush-revert ports and error detection.
// - Top level holds the issue register and handshake logic.
// TESTING
// - Write then read: issue add x5 (rd=5), then consume; next add reads rs1=5 -> dec_ready=0 until wb_valid[0]=1, wb_addr=5; accepts the cycle after.
// - WAW: rd=7 busy, new op rd=7 with no reads -> held; clear 7 -> accepted; busy_mask=32'h80.
// - x0: rd=0 writer, then rs1=0 reader back-to-back -> both accept on consecutive cycles; busy_mask stays 0.
// - Backpressure: iss_ready=0 for 3 cycles with held rd=3 -> iss_fields stable, dec_ready=0, busy[3]=1; iss_ready=1 -> next op issues the following cycle.
// - Flush: held rd=9 plus flush in the same cycle as wb clearing reg 4 -> iss_valid=0, busy[9]=0, busy[4]=0, sb_error=0.
// - Error/race: wb clear of reg 12 while not busy -> sb_error=1, sticky; decode_error op with rd=12 -> issues, busy[12] stays 0; rst -> all outputs 0.

Source files
------------

// File: rtl/rv32_issue_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// rv32_issue_scoreboard_pkg : shared types and hazard helper.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv32_issue_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [31:0] rv32_reg_mask_t;

  typedef struct packed {
    logic        decode_error;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } rv32_fields_t;

  // Bit 0 of the mask is held at zero, so x0 operands never hazard.
  function automatic logic rv32_hazard(input rv32_fields_t   fields,
                                       input logic           uses_rs1,
                                       input logic           uses_rs2,
                                       input logic           writes_rd,
                                       input rv32_reg_mask_t mask);
    return (uses_rs1  && mask[fields.rs1]) ||
           (uses_rs2  && mask[fields.rs2]) ||
           (writes_rd && mask[fields.rd]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_issue_scoreboard_if.sv
// ---------------------------------------------------------------------------
// rv32_issue_scoreboard_if : decode/issue/writeback bundle.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rv32_issue_scoreboard_if #(
  parameter int WB_PORTS = 2
);
  import rv32_issue_scoreboard_pkg::*;

  logic                         dec_valid;
  logic                         dec_ready;
  rv32_fields_t                 dec_fields;
  logic                         dec_uses_rs1;
  logic                         dec_uses_rs2;
  logic                         dec_writes_rd;
  logic                         iss_valid;
  logic                         iss_ready;
  rv32_fields_t                 iss_fields;
  logic                         iss_writes_rd;
  logic [WB_PORTS-1:0]          wb_valid;
  logic [WB_PORTS-1:0][4:0]     wb_addr;
  logic                         flush;
  rv32_reg_mask_t               busy_mask;
  logic                         sb_error;

  modport master (
    output dec_valid, dec_fields, dec_uses_rs1, dec_uses_rs2, dec_writes_rd,
    output iss_ready, wb_valid, wb_addr, flush,
    input  dec_ready, iss_valid, iss_fields, iss_writes_rd, busy_mask, sb_error
  );

  modport slave (
    input  dec_valid, dec_fields, dec_uses_rs1, dec_uses_rs2, dec_writes_rd,
    input  iss_ready, wb_valid, wb_addr, flush,
    output dec_ready, iss_valid, iss_fields, iss_writes_rd, busy_mask, sb_error
  );

endinterface

`default_nettype wire

// File: rtl/rv32_issue_scoreboard_bits.sv
// ---------------------------------------------------------------------------
// rv32_scoreboard_bits : 32-entry busy vector with clear-error detection. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv32_scoreboard_bits
  import rv32_issue_scoreboard_pkg::*;
#(
  parameter int WB_PORTS = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      set_valid_i,
  input  logic [4:0]                set_addr_i,
  input  logic                      revert_valid_i,
  input  logic [4:0]                revert_addr_i,
  input  logic [WB_PORTS-1:0]       wb_valid_i,
  input  logic [WB_PORTS-1:0][4:0]  wb_addr_i,
  output rv32_reg_mask_t            busy_o,
  output logic                      error_o
);

  rv32_reg_mask_t busy_q, busy_d;
  rv32_reg_mask_t set_vec, clr_vec;
  logic           error_q, error_d;
  logic           err_hit;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    err_hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid_i[k] && (wb_addr_i[k] != 5'd0)) begin
        clr_vec[wb_addr_i[k]] = 1'b1;
        if (!busy_q[wb_addr_i[k]]) err_hit = 1'b1;
      end
    end
    // Flush revert is the owner undoing its own mark, never an error.
    if (revert_valid_i) clr_vec[revert_addr_i] = 1'b1;
    if (set_valid_i)    set_vec[set_addr_i]    = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
    error_d   = error_q | err_hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      error_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign busy_o  = busy_q;
  assign error_o = error_q;

endmodule

`default_nettype wire

// File: rtl/rv32_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// rv32_issue_scoreboard : hazard-checked one-deep issue register.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv32_issue_scoreboard
  import rv32_issue_scoreboard_pkg::*;
#(
  parameter int WB_PORTS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  rv32_issue_scoreboard_if.slave  sb_if
);

  rv32_fields_t   iss_fields_q, iss_fields_d;
  logic           iss_valid_q, iss_valid_d;
  logic           iss_writes_rd_q, iss_writes_rd_d;
  rv32_reg_mask_t busy;
  logic           hazard, slot_free, dec_ready, accept, mark, revert;

  always_comb begin
    // Decode-error carriers bypass the hazard check entirely.
    hazard    = !sb_if.dec_fields.decode_error &&
                rv32_hazard(sb_if.dec_fields, sb_if.dec_uses_rs1,
                            sb_if.dec_uses_rs2, sb_if.dec_writes_rd, busy);
    slot_free = !iss_valid_q || sb_if.iss_ready;
    dec_ready = slot_free && !hazard && !sb_if.flush && !rst_i;
    accept    = sb_if.dec_valid && dec_ready;
    mark      = accept && sb_if.dec_writes_rd &&
                (sb_if.dec_fields.rd != 5'd0) && !sb_if.dec_fields.decode_error;
    revert    = sb_if.flush && iss_valid_q && iss_writes_rd_q;

    iss_fields_d    = iss_fields_q;
    iss_valid_d     = iss_valid_q;
    iss_writes_rd_d = iss_writes_rd_q;
    if (sb_if.flush) begin
      iss_valid_d     = 1'b0;
      iss_writes_rd_d = 1'b0;
    end else if (accept) begin
      iss_fields_d    = sb_if.dec_fields;
      iss_valid_d     = 1'b1;
      iss_writes_rd_d = mark;
    end else if (sb_if.iss_ready) begin
      iss_valid_d     = 1'b0;
      iss_writes_rd_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_fields_q    <= '0;
      iss_valid_q     <= 1'b0;
      iss_writes_rd_q <= 1'b0;
    end else begin
      iss_fields_q    <= iss_fields_d;
      iss_valid_q     <= iss_valid_d;
      iss_writes_rd_q <= iss_writes_rd_d;
    end
  end

  rv32_scoreboard_bits #(
    .WB_PORTS (WB_PORTS)
  ) u_bits (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .set_valid_i    (mark),
    .set_addr_i     (sb_if.dec_fields.rd),
    .revert_valid_i (revert),
    .revert_addr_i  (iss_fields_q.rd),
    .wb_valid_i     (sb_if.wb_valid),
    .wb_addr_i      (sb_if.wb_addr),
    .busy_o         (busy),
    .error_o        (sb_if.sb_error)
  );

  assign sb_if.dec_ready     = dec_ready;
  assign sb_if.iss_valid     = iss_valid_q;
  assign sb_if.iss_fields    = iss_fields_q;
  assign sb_if.iss_writes_rd = iss_writes_rd_q;
  assign sb_if.busy_mask     = busy;

endmodule

`default_nettype wire

// File: tb/tb_rv32_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_rv32_issue_scoreboard : cycle-vector bench for the issue scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rv32_issue_scoreboard;
  import rv32_issue_scoreboard_pkg::*;

  typedef struct {
    logic        rs;
    logic        dv;
    logic [7:0]  id;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, wr, derr, ir;
    logic [1:0]  wbv;
    logic [4:0]  wa0, wa1;
    logic        fl;
    logic        e_rdy, e_iv;
    logic [7:0]  e_id;
    logic        e_iwr;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cur = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  rv32_issue_scoreboard_if #(.WB_PORTS(2)) sb_if ();

  rv32_issue_scoreboard #(.WB_PORTS(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb_if (sb_if.slave)
  );

  function automatic vec_t mk(int rs, int dv, int id, int rd, int rs1, int rs2,
                              int u1, int u2, int wr, int derr, int ir, int wbv,
                              int wa0, int wa1, int fl, int e_rdy, int e_iv,
                              int e_id, int e_iwr, int e_busy, int e_err);
    vec_t v;
    v.rs = 1'(rs);     v.dv = 1'(dv);     v.id = 8'(id);
    v.rd = 5'(rd);     v.rs1 = 5'(rs1);   v.rs2 = 5'(rs2);
    v.u1 = 1'(u1);     v.u2 = 1'(u2);     v.wr = 1'(wr);
    v.derr = 1'(derr); v.ir = 1'(ir);     v.wbv = 2'(wbv);
    v.wa0 = 5'(wa0);   v.wa1 = 5'(wa1);   v.fl = 1'(fl);
    v.e_rdy = 1'(e_rdy); v.e_iv = 1'(e_iv); v.e_id = 8'(e_id);
    v.e_iwr = 1'(e_iwr); v.e_busy = 32'(e_busy); v.e_err = 1'(e_err);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, cur, act, exp);
    end
  endtask

  // Drive one cycle, check dec_ready before the edge and state after it.
  task automatic step(input vec_t v);
    rv32_fields_t f;
    f              = '0;
    f.rd           = v.rd;
    f.rs1          = v.rs1;
    f.rs2          = v.rs2;
    f.decode_error = v.derr;
    f.opcode       = 7'h33;
    f.imm          = 32'(v.id);
    rst                 = v.rs;
    sb_if.dec_valid     = v.dv;
    sb_if.dec_fields    = f;
    sb_if.dec_uses_rs1  = v.u1;
    sb_if.dec_uses_rs2  = v.u2;
    sb_if.dec_writes_rd = v.wr;
    sb_if.iss_ready     = v.ir;
    sb_if.wb_valid      = v.wbv;
    sb_if.wb_addr[0]    = v.wa0;
    sb_if.wb_addr[1]    = v.wa1;
    sb_if.flush         = v.fl;
    #3;
    chk("dec_ready", 32'(sb_if.dec_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk("iss_valid",     32'(sb_if.iss_valid),       32'(v.e_iv));
    chk("iss_id",        32'(sb_if.iss_fields.imm),  32'(v.e_id));
    chk("iss_writes_rd", 32'(sb_if.iss_writes_rd),   32'(v.e_iwr));
    chk("busy_mask",     sb_if.busy_mask,            v.e_busy);
    chk("sb_error",      32'(sb_if.sb_error),        32'(v.e_err));
    if (v.rs) chk("iss_fields_rst", 32'(sb_if.iss_fields.rd), 32'd0);
    cur++;
  endtask

  initial begin
    sb_if.dec_valid = 1'b0; sb_if.dec_fields = '0; sb_if.dec_uses_rs1 = 1'b0;
    sb_if.dec_uses_rs2 = 1'b0; sb_if.dec_writes_rd = 1'b0; sb_if.iss_ready = 1'b0;
    sb_if.wb_valid = '0; sb_if.wb_addr = '0; sb_if.flush = 1'b0;

    //                rs dv  id rd r1 r2 u1 u2 wr de ir wbv a0 a1 fl | rdy iv id iwr busy    err
    vecs.push_back(mk(1, 1, 99, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,      0));
    // write x5 then a reader of x5 stalls until the clear retires
    vecs.push_back(mk(0, 1,  1, 5, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1, 1, 1, 'h20,   0));
    vecs.push_back(mk(0, 1,  2, 6, 5, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 'h20,   0));
    vecs.push_back(mk(0, 1,  2, 6, 5, 0, 1, 0, 1, 0, 1, 1, 5, 0, 0,   0, 0, 1, 0, 0,      0));
    vecs.push_back(mk(0, 1,  2, 6, 5, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1, 2, 1, 'h40,   0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0,   1, 0, 2, 0, 0,      0));
    // WAW on x7
    vecs.push_back(mk(0, 1,  3, 7, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1, 3, 1, 'h80,   0));
    vecs.push_back(mk(0, 1,  4, 7, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 3, 0, 'h80,   0));
    vecs.push_back(mk(0, 1,  4, 7, 0, 0, 0, 0, 1, 0, 1, 1, 7, 0, 0,   0, 0, 3, 0, 0,      0));
    vecs.push_back(mk(0, 1,  4, 7, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1, 4, 1, 'h80,   0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0,   1, 0, 4, 0, 0,      0));
    // x0 writer then x0 reader back-to-back
    vecs.push_back(mk(0, 1,  5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1, 5, 0, 0,      0));
    vecs.push_back(mk(0, 1,  6, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 6, 0, 0,      0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 6, 0, 0,      0));
    // flush of held rd=9 alongside a writeback of x4
    vecs.push_back(mk(0, 1,  7, 4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1, 7, 1, 'h10,   0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 7, 0, 'h10,   0));
    vecs.push_back(mk(0, 1,  8, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 1, 8, 1, 'h210,  0));
    vecs.push_back(mk(0, 1,  9,10, 0, 0, 0, 0, 1, 0, 1, 1, 4, 0, 1,   0, 0, 8, 0, 0,      0));
    // both ports clearing x3 together: no error
    vecs.push_back(mk(0, 1, 20, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1,20, 1, 'h8,    0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 3, 0,   1, 0,20, 0, 0,      0));
    // stray clear of x12, then a decode-error carrier with rd=12
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1,12, 0, 0,   1, 0,20, 0, 0,      1));
    vecs.push_back(mk(0, 1, 10,12, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,   1, 1,10, 0, 0,      1));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0,10, 0, 0,      1));
    // set/clear race on x13: set wins
    vecs.push_back(mk(0, 1, 22,13, 0, 0, 0, 0, 1, 0, 1, 2, 0,13, 0,   1, 1,22, 1, 'h2000, 1));
    // decode-error op reading busy x13 still issues
    vecs.push_back(mk(0, 1, 23,13,13, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0,   1, 1,23, 0, 'h2000, 1));

    @(posedge clk);
    #1;
    foreach (vecs[i]) step(vecs[i]);

    // Backpressure: rd=3 held for three cycles, then released.
    step(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1,13, 0, 0,   1, 0,23, 0, 0,      1));
    step(mk(0, 1, 30, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 1,30, 1, 'h8,    1));
    for (int n = 0; n < 3; n++)
      step(mk(0, 1, 31, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1,30, 1, 'h8,    1));
    step(mk(0, 1, 31, 8, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1,31, 1, 'h108,  1));

    // Reset mid-operation clears everything, then normal issue resumes.
    step(mk(1, 1, 32, 5, 0, 0, 0, 0, 1, 0, 1, 1, 3, 0, 0,   0, 0, 0, 0, 0,      0));
    step(mk(0, 1, 40, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,   1, 1,40, 1, 'h4,    0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
